// File: rtl/pio_action_arb_if.sv
// Requester-side command/response bundle for pio_action_arb.
// Packed per-requester fields: requester i occupies slice [i*W +: W].
interface pio_action_arb_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_mindex;
  logic [5*NREQ-1:0]  req_index;
  logic [4*NREQ-1:0]  req_action;
  logic [32*NREQ-1:0] req_din;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_data;

  modport master (
    output req_valid, req_mindex, req_index, req_action, req_din,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_mindex, req_index, req_action, req_din,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pio_action_arb.sv
// Arbitrates NREQ requesters onto the single PIO action port, pulses do_action and returns read data.
// Round-robin by default; define PIO_ARB_FIXED_PRIO_EN for strict lowest-index priority.
module pio_action_arb #(
  parameter int          NREQ    = 3,
  parameter int          RD_LAT  = 2,
  parameter int          GAP_CYC = 1,
  parameter logic [15:0] RD_MASK = 16'h00F0
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_action_arb_if.slave      req_bus,
  output logic [1:0]           pio_mindex,
  output logic [4:0]           pio_index,
  output logic [3:0]           pio_action,
  output logic [31:0]          pio_din,
  output logic                 pio_do_action,
  input  logic [31:0]          pio_dout,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]      state;
  logic [7:0]      lat_cnt;
  logic [3:0]      gap_cnt;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_data_q;

  logic [7:0]      valid8;
  logic [2:0]      start;
  logic [2:0]      win;
  logic [3:0]      idx;
  logic            found;
  logic            grant;
  logic [1:0]      sel_mindex;
  logic [4:0]      sel_index;
  logic [3:0]      sel_action;
  logic [31:0]     sel_din;

`ifdef PIO_ARB_FIXED_PRIO_EN
  assign start = 3'd0;
`else
  logic [2:0] ptr;
  // A pointer outside the requester range restarts the search at 0.
  assign start = ({1'b0, ptr} >= 4'(NREQ)) ? 3'd0 : ptr;
`endif

  assign valid8 = 8'(req_bus.req_valid);

  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, start} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && valid8[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  assign grant = (state == IDLE) && found;

  always_comb begin
    req_bus.req_ready = '0;
    sel_mindex = 2'd0;
    sel_index  = 5'd0;
    sel_action = 4'd0;
    sel_din    = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        req_bus.req_ready[i] = grant;
        sel_mindex = req_bus.req_mindex[i*2 +: 2];
        sel_index  = req_bus.req_index[i*5 +: 5];
        sel_action = req_bus.req_action[i*4 +: 4];
        sel_din    = req_bus.req_din[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pio_mindex    <= '0;
      pio_index     <= '0;
      pio_action    <= '0;
      pio_din       <= '0;
      pio_do_action <= 1'b0;
      grant_id      <= '0;
      lat_cnt       <= '0;
      gap_cnt       <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else begin
      pio_do_action <= 1'b0;
      rsp_valid_q   <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            pio_mindex    <= sel_mindex;
            pio_index     <= sel_index;
            pio_action    <= sel_action;
            pio_din       <= sel_din;
            grant_id      <= win;
            pio_do_action <= 1'b1;
            state         <= ISSUE;
`ifndef PIO_ARB_FIXED_PRIO_EN
            ptr           <= (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
`endif
          end
        end
        ISSUE: begin
          if (RD_MASK[pio_action]) begin
            lat_cnt <= 8'(RD_LAT-1);
            state   <= WAIT;
          end else if (GAP_CYC == 0) begin
            state   <= IDLE;
          end else begin
            gap_cnt <= 4'(GAP_CYC-1);
            state   <= GAP;
          end
        end
        WAIT: begin
          if (lat_cnt == 8'd0) begin
            rsp_data_q  <= pio_dout;
            rsp_valid_q <= NREQ'(1) << grant_id;
            if (GAP_CYC == 0) begin
              state   <= IDLE;
            end else begin
              gap_cnt <= 4'(GAP_CYC-1);
              state   <= GAP;
            end
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        default: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
      endcase
    end
  end

  assign req_bus.rsp_valid = rsp_valid_q;
  assign req_bus.rsp_data  = rsp_data_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_pio_action_arb.sv
// Directed bench for pio_action_arb: default instance (GAP_CYC=1) plus a GAP_CYC=0 instance.
module tb_pio_action_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  pio_mindex_a, pio_mindex_b;
  logic [4:0]  pio_index_a, pio_index_b;
  logic [3:0]  pio_action_a, pio_action_b;
  logic [31:0] pio_din_a, pio_din_b;
  logic        pio_do_action_a, pio_do_action_b;
  logic [31:0] pio_dout_a, pio_dout_b;
  logic        busy_a, busy_b;
  logic [2:0]  grant_id_a, grant_id_b;

  int tests  = 0;
  int failed = 0;

  pio_action_arb_if #(.NREQ(3)) rbus_a ();
  pio_action_arb_if #(.NREQ(3)) rbus_b ();

  pio_action_arb #(.NREQ(3), .RD_LAT(2), .GAP_CYC(1), .RD_MASK(16'h00F0)) dut_a (
    .clk(clk), .reset(reset), .req_bus(rbus_a),
    .pio_mindex(pio_mindex_a), .pio_index(pio_index_a), .pio_action(pio_action_a),
    .pio_din(pio_din_a), .pio_do_action(pio_do_action_a), .pio_dout(pio_dout_a),
    .busy(busy_a), .grant_id(grant_id_a)
  );

  pio_action_arb #(.NREQ(3), .RD_LAT(2), .GAP_CYC(0), .RD_MASK(16'h00F0)) dut_b (
    .clk(clk), .reset(reset), .req_bus(rbus_b),
    .pio_mindex(pio_mindex_b), .pio_index(pio_index_b), .pio_action(pio_action_b),
    .pio_din(pio_din_b), .pio_do_action(pio_do_action_b), .pio_dout(pio_dout_b),
    .busy(busy_b), .grant_id(grant_id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d [3];
    logic [2:0]  exp_g;
    int n;
    d[0] = 32'h1111_0000;
    d[1] = 32'h2222_0001;
    d[2] = 32'h3333_0002;

    rbus_a.req_valid = '0; rbus_a.req_mindex = '0; rbus_a.req_index = '0;
    rbus_a.req_action = '0; rbus_a.req_din = '0;
    rbus_b.req_valid = '0; rbus_b.req_mindex = '0; rbus_b.req_index = '0;
    rbus_b.req_action = '0; rbus_b.req_din = '0;
    pio_dout_a = '0; pio_dout_b = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_busy", busy_a, 0);
    chk("rst_do_action", pio_do_action_a, 0);
    chk("rst_ready", rbus_a.req_ready, 0);
    chk("rst_rsp_valid", rbus_a.rsp_valid, 0);
    chk("rst_grant_id", grant_id_a, 0);
    chk("rst_pio_din", pio_din_a, 0);

    // Single write from requester 1
    rbus_a.req_valid[1] = 1'b1;
    rbus_a.req_action[4 +: 4] = 4'h2;
    rbus_a.req_din[32 +: 32] = 32'hA5A5_0001;
    rbus_a.req_mindex[2 +: 2] = 2'd3;
    rbus_a.req_index[5 +: 5] = 5'd17;
    #1;
    chk("wr_ready_T", rbus_a.req_ready, 3'b010);
    tick();
    rbus_a.req_valid[1] = 1'b0;
    chk("wr_do_action_T1", pio_do_action_a, 1);
    chk("wr_pio_din", pio_din_a, 32'hA5A5_0001);
    chk("wr_pio_action", pio_action_a, 4'h2);
    chk("wr_pio_mindex", pio_mindex_a, 2'd3);
    chk("wr_pio_index", pio_index_a, 5'd17);
    chk("wr_grant_id", grant_id_a, 1);
    chk("wr_busy_T1", busy_a, 1);
    tick();
    chk("wr_do_action_T2", pio_do_action_a, 0);
    chk("wr_busy_T2", busy_a, 1);
    tick();
    chk("wr_busy_T3", busy_a, 0);

    // Read from requester 0
    rbus_a.req_valid[0] = 1'b1;
    rbus_a.req_action[0 +: 4] = 4'h4;
    rbus_a.req_din[0 +: 32] = 32'h0000_00AA;
    pio_dout_a = 32'hDEAD_BEEF;
    #1;
    chk("rd_ready_T", rbus_a.req_ready, 3'b001);
    tick();
    rbus_a.req_valid[0] = 1'b0;
    chk("rd_do_action_T1", pio_do_action_a, 1);
    chk("rd_pio_action", pio_action_a, 4'h4);
    tick();
    chk("rd_rsp_T2", rbus_a.rsp_valid, 0);
    tick();
    chk("rd_rsp_T3", rbus_a.rsp_valid, 0);
    tick();
    chk("rd_rsp_T4", rbus_a.rsp_valid, 3'b001);
    chk("rd_rsp_data", rbus_a.rsp_data, 32'hDEAD_BEEF);
    chk("rd_busy_T4", busy_a, 1);
    tick();
    chk("rd_rsp_T5", rbus_a.rsp_valid, 0);
    chk("rd_data_hold", rbus_a.rsp_data, 32'hDEAD_BEEF);
    chk("rd_busy_T5", busy_a, 0);

    // Fairness: all requesters valid continuously from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rbus_a.req_valid = 3'b111;
    rbus_a.req_action = {4'h2, 4'h2, 4'h2};
    #1;
    for (int k = 0; k < 6; k++) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
      exp_g = 3'd0;
`else
      exp_g = 3'(k % 3);
`endif
      n = 0;
      while (rbus_a.req_ready == 3'b000 && n < 12) begin
        tick();
        n++;
      end
      chk($sformatf("fair_ready_%0d", k), rbus_a.req_ready, 32'd1 << exp_g);
      tick();
      chk($sformatf("fair_grant_id_%0d", k), grant_id_a, exp_g);
    end
    rbus_a.req_valid = '0;
    tick(); tick(); tick();
    chk("fair_idle", busy_a, 0);

    // Requester 2 raises valid during GAP and drops it before IDLE
    rbus_a.req_valid[1] = 1'b1;
    #1;
    chk("drop_w1_ready", rbus_a.req_ready, 3'b010);
    tick();
    rbus_a.req_valid[1] = 1'b0;
    tick();
    rbus_a.req_valid[2] = 1'b1;
    #1;
    chk("drop_ready_gap", rbus_a.req_ready, 0);
    rbus_a.req_valid[2] = 1'b0;
    tick();
    chk("drop_busy", busy_a, 0);
    chk("drop_ready_idle", rbus_a.req_ready, 0);
    tick();
    chk("drop_do_action", pio_do_action_a, 0);
    chk("drop_grant_id", grant_id_a, 1);

    // Reset during WAIT abandons the read
    rbus_a.req_valid[2] = 1'b1;
    rbus_a.req_action[8 +: 4] = 4'h5;
    rbus_a.req_din[64 +: 32] = 32'hCAFE_0002;
    pio_dout_a = 32'h1234_5678;
    #1;
    chk("rst_rd_ready", rbus_a.req_ready, 3'b100);
    tick();
    rbus_a.req_valid[2] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_rd_busy", busy_a, 0);
    chk("rst_rd_rsp", rbus_a.rsp_valid, 0);
    chk("rst_rd_din", pio_din_a, 0);
    chk("rst_rd_action", pio_action_a, 0);
    chk("rst_rd_grant", grant_id_a, 0);
    chk("rst_rd_rsp_data", rbus_a.rsp_data, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_rd_no_rsp_%0d", k), rbus_a.rsp_valid, 0);
    end
    rbus_a.req_valid = 3'b101;
    rbus_a.req_action[8 +: 4] = 4'h2;
    #1;
    chk("rst_first_ready", rbus_a.req_ready, 3'b001);
    tick();
    rbus_a.req_valid = '0;
    chk("rst_first_grant", grant_id_a, 0);
    chk("rst_first_do", pio_do_action_a, 1);
    tick(); tick();

    // GAP_CYC=0: back-to-back writes from requester 1
    rbus_b.req_valid[1] = 1'b1;
    rbus_b.req_action[4 +: 4] = 4'h1;
    for (int k = 0; k < 3; k++) begin
      rbus_b.req_din[32 +: 32] = d[k];
      #1;
      chk($sformatf("b2b_ready_%0d", k), rbus_b.req_ready, 3'b010);
      tick();
      chk($sformatf("b2b_do_%0d", k), pio_do_action_b, 1);
      chk($sformatf("b2b_din_%0d", k), pio_din_b, d[k]);
      chk($sformatf("b2b_ready_issue_%0d", k), rbus_b.req_ready, 0);
      tick();
      chk($sformatf("b2b_do_low_%0d", k), pio_do_action_b, 0);
    end
    rbus_b.req_valid = '0;
    tick();
    chk("b2b_idle", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
